result_sel_pipe: RTL and testbench
==================================

Name: result_sel_pipe

Overview:
- Parametrised, registered successor to the combinational result multiplexer.
- Selects one of NCH operation-result channels and attaches a per-channel flag bit.
- Passes the selected result through a valid/ready pipeline stage with a 2-entry skid buffer, so full throughput is kept under backpressure.
- Sits between the operation units and the result writeback/display logic; invalid selects are reported instead of silently producing zero.

Parameters:
- WIDTH, 16: result data width in bits.
- NCH, 6: number of input result channels (2..16).
- SELW, 3: select width; must satisfy 2**SELW >= NCH.
- FLAG_MASK, 6'b011010: NCH-bit vector; bit i is the flag value emitted with channel i (default flags channels 1, 3 and 4).

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_data, input, NCH*WIDTH: flattened channel results; channel i occupies bits [i*WIDTH +: WIDTH].
- in_sel, input, SELW: channel select, sampled with in_valid.
- in_valid, input, 1: upstream request valid.
- in_ready, output, 1: block can accept a request this cycle.
- out_data, output, WIDTH: selected result.
- out_flag, output, 1: FLAG_MASK[sel] of the selected channel; 0 for an invalid select.
- out_valid, output, 1: out_data/out_flag are valid.
- out_ready, input, 1: downstream accepts the output.
- sel_err, output, 1: sticky flag, set when a request with in_sel >= NCH is accepted.
- err_clr, input, 1: synchronous clear of sel_err.

Behaviour:
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Upstream must hold in_data/in_sel stable while in_valid && !in_ready.
- Storage: main output register plus one skid register. Both hold {data, flag}.
- State machine (registered occupancy count):
  - EMPTY: out_valid=0, in_ready=1. An accepted input loads main and moves to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept and drain in the same cycle: main reloads, stay in ONE.
    - Accept without drain: load skid, move to FULL.
    - Drain without accept: move to EMPTY.
  - FULL: out_valid=1, in_ready=0. On drain, skid moves into main and the state becomes ONE.
- in_ready is a registered signal (state != FULL). It is never combinationally dependent on out_ready.
- Latency: the first output is valid the cycle after acceptance. Throughput is 1 transfer/cycle when out_ready is held high.
- Ordering is strictly FIFO; no request is dropped or duplicated.
- Select decode:
  - in_sel < NCH: data = channel in_sel, flag = FLAG_MASK[in_sel].
  - in_sel >= NCH: data = 0, flag = 0, and sel_err is set on the acceptance edge. The request is still accepted and forwarded.
- sel_err simultaneous events: if err_clr and a new invalid accept occur in the same cycle, set wins (sel_err=1).
- Reset (async assert, sync deassert handled externally):
  - State goes to EMPTY.
  - out_data=0, out_flag=0, out_valid=0, sel_err=0, in_ready=1 after reset.
  - Reset mid-operation discards both buffered entries.
- Width rule: out_data is exactly WIDTH bits; no sign extension and no arithmetic is performed.

Optional Feature:
- Macro: RESULT_SEL_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0].
  - Increments on every accepted invalid select.
  - Saturates at 8'hFF.
  - Cleared by err_clr and by reset.
  - A same-cycle clear and increment loads 8'd1.
- Undefined: port and counter are absent; sel_err behaviour is unchanged.

Test Plan:
- Reset: hold rst_n=0 with random inputs, release -> out_valid=0, in_ready=1, out_data=0, sel_err=0.
- Basic select: WIDTH=16, channels 0..5 = 16'h1000+i, out_ready=1, send sel 0..5 on consecutive cycles.
  - Expect out_data 16'h1000..16'h1005 on consecutive cycles, one cycle after each accept.
  - Expect out_flag sequence 0,1,0,1,1,0.
- Backpressure: send 3 requests back-to-back with out_ready=0.
  - Expect in_ready=0 after the 2nd accept and the 3rd held.
  - Raise out_ready -> outputs appear in order, with no loss and no duplicate.
- Invalid select: send sel=6, then sel=7.
  - Expect out_data=0, out_flag=0, sel_err=1 after the first accept.
  - With RESULT_SEL_ERR_CNT_EN defined, err_cnt=2.
  - Pulse err_clr -> sel_err=0 and err_cnt=0.
- Simultaneous clear and error: err_clr=1 in the same cycle as an accepted sel=7 -> sel_err=1 and err_cnt=1.
- Reset mid-operation: fill to FULL, assert rst_n=0 -> out_valid=0 immediately (async); after release, the buffer is empty and in_ready=1.

Source files
------------

// File: rtl/result_sel_pipe.sv
// Registered result selector: picks one of NCH channels, attaches a per-channel flag,
// and forwards it through a valid/ready stage with a 2-entry skid buffer.
// Optional: define RESULT_SEL_ERR_CNT_EN to add the saturating err_cnt output.
module result_sel_pipe #(
  parameter int unsigned     WIDTH     = 16,
  parameter int unsigned     NCH       = 6,
  parameter int unsigned     SELW      = 3,
  parameter logic [NCH-1:0]  FLAG_MASK = NCH'(6'b011010)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_flag,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  err_clr,
  output logic                  sel_err
`ifdef RESULT_SEL_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             flag;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t skid;
  entry_t dec;
  logic   dec_bad;
  logic   accept;
  logic   drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Select decode; out-of-range selects yield zero data and flag and are reported.
  always_comb begin
    dec     = '0;
    dec_bad = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (in_sel == SELW'(i)) begin
        dec.data = in_data[i*WIDTH +: WIDTH];
        dec.flag = FLAG_MASK[i];
        dec_bad  = 1'b0;
      end
    end
  end

  // Occupancy FSM; out_data/out_flag act as the main register, in_ready and
  // out_valid are registered alongside the state so neither depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      out_data  <= '0;
      out_flag  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      skid      <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_data  <= dec.data;
            out_flag  <= dec.flag;
            out_valid <= 1'b1;
            state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            out_data <= dec.data;
            out_flag <= dec.flag;
          end else if (accept) begin
            skid     <= dec;
            in_ready <= 1'b0;
            state    <= S_FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (drain) begin
            out_data <= skid.data;
            out_flag <= skid.flag;
            in_ready <= 1'b1;
            state    <= S_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_EMPTY;
        end
      endcase
    end
  end

  // Sticky select error; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept && dec_bad) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

`ifdef RESULT_SEL_ERR_CNT_EN
  // Saturating count of accepted invalid selects; clear-plus-error restarts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      err_cnt <= (accept && dec_bad) ? 8'd1 : 8'd0;
    end else if (accept && dec_bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_result_sel_pipe.sv
// Bench for result_sel_pipe: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations and a randomized phase.
module tb_result_sel_pipe;

  localparam int WIDTH = 16;
  localparam int NCH   = 6;
  localparam int SELW  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [SELW-1:0]      in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_flag;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err_clr;
  logic                 sel_err;
`ifdef RESULT_SEL_ERR_CNT_EN
  logic [7:0]           err_cnt;
`endif

  result_sel_pipe #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_flag(out_flag), .out_valid(out_valid), .out_ready(out_ready),
    .err_clr(err_clr), .sel_err(sel_err)
`ifdef RESULT_SEL_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             f;
  } item_t;

  logic [WIDTH-1:0] ch [NCH];
  int               flag_tbl [NCH] = '{0, 1, 0, 1, 1, 0};
  item_t            q [$];
  logic             m_err = 1'b0;
  int               m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_ch();
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = ch[i];
  endtask

  function automatic item_t expect_of(input logic [SELW-1:0] s);
    item_t it;
    int    idx;
    idx = int'(s);
    it  = '0;
    if (idx < NCH) begin
      it.d = ch[idx];
      it.f = (flag_tbl[idx] != 0);
    end
    return it;
  endfunction

  // Reference model: a FIFO of at most two entries plus a sticky error bit and counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      automatic bit acc = in_valid && (q.size() < 2);
      automatic bit drn = out_ready && (q.size() > 0);
      automatic bit bad = acc && (int'(in_sel) >= NCH);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(expect_of(in_sel));
      if (bad) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (err_clr) m_cnt = bad ? 1 : 0;
      else if (bad && m_cnt < 255) m_cnt++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("sel_err", 32'(sel_err), 32'(m_err));
`ifdef RESULT_SEL_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
      if (q.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(q[0].d));
        chk("out_flag", 32'(out_flag), 32'(q[0].f));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'($urandom);
    in_sel    = SELW'($urandom);
    out_ready = 1'($urandom);
    err_clr   = 1'($urandom);
    for (int i = 0; i < NCH; i++) ch[i] = WIDTH'($urandom);
    load_ch();
    idle(3);
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);

    // Basic select, one output per cycle.
    for (int i = 0; i < NCH; i++) ch[i] = WIDTH'(16'h1000 + i);
    load_ch();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 3'd0;
    for (int i = 0; i < NCH; i++) begin
      @(negedge clk);
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_data", 32'(out_data), 32'(16'h1000 + i));
      chk("basic_flag", 32'(out_flag), 32'(flag_tbl[i]));
      if (i < NCH - 1) in_sel = SELW'(i + 1);
      else in_valid = 1'b0;
    end
    idle(2);

    // Backpressure: three back-to-back requests with the sink stalled.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd0;
    @(negedge clk); in_sel = 3'd1;
    @(negedge clk); in_sel = 3'd2;
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("bp_held", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(out_data), 32'h1000);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second", 32'(out_data), 32'h1001);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_third", 32'(out_data), 32'h1002);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Invalid selects and clear.
    in_valid = 1'b1; in_sel = 3'd6;
    @(negedge clk);
    chk("inv_data", 32'(out_data), 32'd0);
    chk("inv_flag", 32'(out_flag), 32'd0);
    chk("inv_err", 32'(sel_err), 32'd1);
    in_sel = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef RESULT_SEL_ERR_CNT_EN
    chk("inv_cnt2", 32'(err_cnt), 32'd2);
`endif
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_err", 32'(sel_err), 32'd0);
`ifdef RESULT_SEL_ERR_CNT_EN
    chk("clr_cnt", 32'(err_cnt), 32'd0);
`endif

    // Clear and new error in the same cycle: set wins.
    in_valid = 1'b1; in_sel = 3'd7; err_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; err_clr = 1'b0;
    chk("sim_err", 32'(sel_err), 32'd1);
`ifdef RESULT_SEL_ERR_CNT_EN
    chk("sim_cnt", 32'(err_cnt), 32'd1);
`endif
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    idle(1);

    // Reset while full.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd3;
    @(negedge clk); in_sel = 3'd4;
    @(negedge clk);
    chk("mid_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(out_valid), 32'd0);
    chk("mid_async_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_ready", 32'(in_ready), 32'd1);
    chk("mid_after_valid", 32'(out_valid), 32'd0);

    // Randomized traffic obeying the hold rule.
    for (int n = 0; n < 3000; n++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(3) != 0);
        in_sel   = SELW'($urandom_range(7));
        for (int i = 0; i < NCH; i++) ch[i] = WIDTH'($urandom);
        load_ch();
      end
      out_ready = ($urandom_range(9) < 7);
      err_clr   = ($urandom_range(15) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
